// File: rtl/memory_arbiter_rv32.sv
// Shares the rv32 core's single memory port between instruction fetch and load/store.
// Define MEMORY_ARBITER_ROUND_ROBIN_EN for round-robin conflicts instead of data priority with starvation override.
module memory_arbiter_rv32 #(
   parameter int ADDRESS_WIDTH    = 32,
   parameter int DATA_WIDTH       = 32,
   parameter int MEMORY_LATENCY   = 1,
   parameter int STARVATION_LIMIT = 4
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     fetch_request,
   input  logic [ADDRESS_WIDTH-1:0] fetch_address,
   output logic                     fetch_grant,
   output logic                     fetch_valid,
   output logic [DATA_WIDTH-1:0]    fetch_instruction,
   input  logic                     data_request,
   input  logic                     data_write,
   input  logic [ADDRESS_WIDTH-1:0] data_address,
   input  logic [DATA_WIDTH-1:0]    data_write_value,
   input  logic [3:0]               data_byte_enable,
   output logic                     data_grant,
   output logic                     data_valid,
   output logic [DATA_WIDTH-1:0]    data_read_value,
   output logic [ADDRESS_WIDTH-1:0] memory_read_address,
   output logic                     read_enable,
   input  logic [DATA_WIDTH-1:0]    memory_read_value,
   output logic                     write_enable,
   output logic [DATA_WIDTH-1:0]    memory_write_value,
   output logic [3:0]               memory_byte_enable,
   output logic                     busy
);

   localparam int LAT_W = (MEMORY_LATENCY > 1) ? $clog2(MEMORY_LATENCY) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_WAIT,
      ST_RESPOND
   } state_t;

   state_t                   state_q, state_d;
   logic [LAT_W-1:0]         wait_cnt_q, wait_cnt_d;
   logic                     owner_fetch_q, owner_fetch_d;
   logic                     is_write_q, is_write_d;
   logic                     fetch_grant_q, fetch_grant_d;
   logic                     fetch_valid_q, fetch_valid_d;
   logic [DATA_WIDTH-1:0]    fetch_instruction_q, fetch_instruction_d;
   logic                     data_grant_q, data_grant_d;
   logic                     data_valid_q, data_valid_d;
   logic [DATA_WIDTH-1:0]    data_read_value_q, data_read_value_d;
   logic [ADDRESS_WIDTH-1:0] address_q, address_d;
   logic                     read_enable_q, read_enable_d;
   logic                     write_enable_q, write_enable_d;
   logic [DATA_WIDTH-1:0]    write_value_q, write_value_d;
   logic [3:0]               byte_enable_q, byte_enable_d;
   logic                     busy_q, busy_d;
   logic                     fetch_wins, data_wins;

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
   logic last_fetch_q, last_fetch_d;

   // On a conflict the side that lost the previous arbitration goes first.
   always_comb begin
      fetch_wins = fetch_request && (!data_request || !last_fetch_q);
      data_wins  = data_request && !fetch_wins;
   end
`else
   localparam int STARVE_W = $clog2(STARVATION_LIMIT + 1);
   logic [STARVE_W-1:0] starve_q, starve_d;

   always_comb begin
      fetch_wins = fetch_request &&
                   (!data_request || (starve_q == STARVE_W'(STARVATION_LIMIT)));
      data_wins  = data_request && !fetch_wins;
   end
`endif

   always_comb begin
      state_d             = state_q;
      wait_cnt_d          = wait_cnt_q;
      owner_fetch_d       = owner_fetch_q;
      is_write_d          = is_write_q;
      fetch_grant_d       = 1'b0;
      fetch_valid_d       = 1'b0;
      fetch_instruction_d = fetch_instruction_q;
      data_grant_d        = 1'b0;
      data_valid_d        = 1'b0;
      data_read_value_d   = data_read_value_q;
      address_d           = '0;
      read_enable_d       = 1'b0;
      write_enable_d      = 1'b0;
      write_value_d       = '0;
      byte_enable_d       = '0;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
      last_fetch_d        = last_fetch_q;
`else
      starve_d            = starve_q;
`endif
      case (state_q)
         ST_IDLE, ST_RESPOND: begin
            state_d = ST_IDLE;
            if (fetch_wins) begin
               state_d       = ST_ACCESS;
               owner_fetch_d = 1'b1;
               is_write_d    = 1'b0;
               fetch_grant_d = 1'b1;
               read_enable_d = 1'b1;
               address_d     = fetch_address;
            end else if (data_wins) begin
               state_d        = ST_ACCESS;
               owner_fetch_d  = 1'b0;
               is_write_d     = data_write;
               data_grant_d   = 1'b1;
               read_enable_d  = !data_write;
               write_enable_d = data_write;
               address_d      = data_address;
               if (data_write) begin
                  write_value_d = data_write_value;
                  byte_enable_d = data_byte_enable;
               end
            end
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
            if (fetch_wins) begin
               last_fetch_d = 1'b1;
            end else if (data_wins) begin
               last_fetch_d = 1'b0;
            end
`else
            if (!fetch_request || fetch_wins) begin
               starve_d = '0;
            end else if (starve_q != STARVE_W'(STARVATION_LIMIT)) begin
               starve_d = starve_q + 1'b1;
            end
`endif
         end
         ST_ACCESS: begin
            if (is_write_q) begin
               state_d      = ST_RESPOND;
               data_valid_d = 1'b1;
            end else begin
               state_d    = ST_WAIT;
               wait_cnt_d = '0;
            end
         end
         ST_WAIT: begin
            // Memory data is captured on the last latency cycle and presented in RESPOND.
            if (wait_cnt_q == LAT_W'(MEMORY_LATENCY - 1)) begin
               state_d = ST_RESPOND;
               if (owner_fetch_q) begin
                  fetch_valid_d       = 1'b1;
                  fetch_instruction_d = memory_read_value;
               end else begin
                  data_valid_d      = 1'b1;
                  data_read_value_d = memory_read_value;
               end
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_ACCESS) || (state_d == ST_WAIT);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q             <= ST_IDLE;
         wait_cnt_q          <= '0;
         owner_fetch_q       <= 1'b0;
         is_write_q          <= 1'b0;
         fetch_grant_q       <= 1'b0;
         fetch_valid_q       <= 1'b0;
         fetch_instruction_q <= '0;
         data_grant_q        <= 1'b0;
         data_valid_q        <= 1'b0;
         data_read_value_q   <= '0;
         address_q           <= '0;
         read_enable_q       <= 1'b0;
         write_enable_q      <= 1'b0;
         write_value_q       <= '0;
         byte_enable_q       <= '0;
         busy_q              <= 1'b0;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
         last_fetch_q        <= 1'b0;
`else
         starve_q            <= '0;
`endif
      end else begin
         state_q             <= state_d;
         wait_cnt_q          <= wait_cnt_d;
         owner_fetch_q       <= owner_fetch_d;
         is_write_q          <= is_write_d;
         fetch_grant_q       <= fetch_grant_d;
         fetch_valid_q       <= fetch_valid_d;
         fetch_instruction_q <= fetch_instruction_d;
         data_grant_q        <= data_grant_d;
         data_valid_q        <= data_valid_d;
         data_read_value_q   <= data_read_value_d;
         address_q           <= address_d;
         read_enable_q       <= read_enable_d;
         write_enable_q      <= write_enable_d;
         write_value_q       <= write_value_d;
         byte_enable_q       <= byte_enable_d;
         busy_q              <= busy_d;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
         last_fetch_q        <= last_fetch_d;
`else
         starve_q            <= starve_d;
`endif
      end
   end

   assign fetch_grant         = fetch_grant_q;
   assign fetch_valid         = fetch_valid_q;
   assign fetch_instruction   = fetch_instruction_q;
   assign data_grant          = data_grant_q;
   assign data_valid          = data_valid_q;
   assign data_read_value     = data_read_value_q;
   assign memory_read_address = address_q;
   assign read_enable         = read_enable_q;
   assign write_enable        = write_enable_q;
   assign memory_write_value  = write_value_q;
   assign memory_byte_enable  = byte_enable_q;
   assign busy                = busy_q;

endmodule
